mc_controller: RTL

Multicycle control unit for the RISC-V core's shared-memory datapath variant. It sequences a single ALU and a single unified memory port through fetch, decode, execute, memory and writeback states for lw, sw, R-type, I-type ALU, beq and jal. It adds a memory-ready handshake with a timeout. It sits beside the datapath and drives all of its mux selects and write enables.

---
 rtl/mc_controller.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle control unit for the shared-memory RISC-V datapath.
// Sequences the single ALU and the unified memory port, with a memory-ready timeout.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | compute branch/jump target OldPC+imm, dispatch on opcode
// MEMADR   | compute rs1+imm load/store address
// MEMREAD  | wait for load data
// MEMWB    | write load data to register file
// MEMWRITE | hold store request until memory ready
// EXECUTER | register-register ALU operation
// EXECUTEI | register-immediate ALU operation
// ALUWB    | write ALU result to register file
// BEQ      | compare rs1-rs2, take branch on zero
// JAL      | redirect PC, form link address OldPC+4
module mc_controller #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Retire,
   output logic       Fault,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

   state_t     state, state_next;
   aluop_t     alu_op;
   logic [7:0] wait_cnt, wait_cnt_next;
   logic       is_wait, timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   assign is_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   assign timeout = is_wait && !MemReady && (wait_cnt == WAIT_TC);

   always_comb begin
      state_next = state;
      alu_op     = ALUOP_ADD;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      RegWrite   = 1'b0;
      Retire     = 1'b0;
      Fault      = 1'b0;
      unique case (state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (timeout) begin
               Fault = 1'b1;
            end else begin
               IRWrite = MemReady;
               PCWrite = MemReady;
               if (MemReady) state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               7'b0000011, 7'b0100011: state_next = S_MEMADR;
               7'b0110011:             state_next = S_EXECUTER;
               7'b0010011:             state_next = S_EXECUTEI;
               7'b1100011:             state_next = S_BEQ;
               7'b1101111:             state_next = S_JAL;
               default: begin
                  state_next = S_FETCH;
                  Fault      = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            state_next = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) begin
               state_next = S_MEMWB;
            end else if (timeout) begin
               Fault      = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            Retire     = 1'b1;
            state_next = S_FETCH;
         end
         // The store request stays up on the timeout cycle so a late MemReady still completes it.
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (MemReady) begin
               Retire     = 1'b1;
               state_next = S_FETCH;
            end else if (timeout) begin
               Fault      = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXECUTER: begin
            ALUSrcA    = 2'b10;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            Retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA    = 2'b10;
            alu_op     = ALUOP_SUB;
            PCWrite    = Zero;
            Retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            PCWrite    = 1'b1;
            state_next = S_ALUWB;
         end
         default: state_next = S_FETCH;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         Retire   = 1'b0;
         Fault    = 1'b0;
      end
   end

   // Any state change, or a timeout that re-enters FETCH, restarts the wait count.
   always_comb begin
      wait_cnt_next = wait_cnt;
      if ((state_next != state) || timeout) wait_cnt_next = '0;
      else if (is_wait && !MemReady)        wait_cnt_next = wait_cnt + 8'd1;
   end

   always_comb begin
      ALUControl = 3'b000;
      unique case (alu_op)
         ALUOP_SUB: ALUControl = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         7'b0100011: ImmSrc = 2'b01;
         7'b1100011: ImmSrc = 2'b10;
         7'b1101111: ImmSrc = 2'b11;
         default:    ImmSrc = 2'b00;
      endcase
   end

   assign State = state;

endmodule
